// File: rtl/tdoa_coder_pkg.sv
// -----------------------------------------------------------------------------
// tdoa_pkg
// Shared types and helpers for the TDOA delay coder.
//   state_e  : controller states (IDLE, CAPTURE, COMPUTE, HOLD)
//   CODE_W   : width of each published lag code
//   TS_W     : width of the tick counter and per-channel timestamps
//   HOLD_W   : width of the hold-off cycle counter
//   sat127() : clamps a signed timestamp difference into a 0..127 lag code
// -----------------------------------------------------------------------------
package tdoa_pkg;

  localparam int CODE_W = 7;
  localparam int TS_W   = 8;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPUTE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Negative lags (this sensor fired first) map to 0; lags beyond the code
  // range saturate at 127.
  function automatic logic [CODE_W-1:0] sat127(input logic signed [TS_W:0] diff);
    if (diff <= 9'sd0) begin
      return '0;
    end else if (diff > 9'sd127) begin
      return 7'd127;
    end else begin
      return diff[CODE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tdoa_coder_if.sv
// -----------------------------------------------------------------------------
// tdoa_coder_if
// Sensor-side and result-side signals of the TDOA delay coder.
//   det_x1/x2/y1/y2   : raw asynchronous detect lines (into the coder)
//   code_x1/x2/y1/y2  : 7-bit lag codes, held between publishes
//   code_valid        : one-cycle strobe when new codes are published
//   timeout           : one-cycle strobe when a window expires incomplete
//   busy              : high whenever the coder is not idle
// master drives the detect lines and consumes results; slave is the coder.
// -----------------------------------------------------------------------------
interface tdoa_coder_if;
  import tdoa_pkg::*;

  logic              det_x1;
  logic              det_x2;
  logic              det_y1;
  logic              det_y2;
  logic [CODE_W-1:0] code_x1;
  logic [CODE_W-1:0] code_x2;
  logic [CODE_W-1:0] code_y1;
  logic [CODE_W-1:0] code_y2;
  logic              code_valid;
  logic              timeout;
  logic              busy;

  modport master (
    output det_x1, det_x2, det_y1, det_y2,
    input  code_x1, code_x2, code_y1, code_y2, code_valid, timeout, busy
  );

  modport slave (
    input  det_x1, det_x2, det_y1, det_y2,
    output code_x1, code_x2, code_y1, code_y2, code_valid, timeout, busy
  );

endinterface

// File: rtl/tdoa_coder_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer followed by a registered rising-edge detector.
//   clock : system clock
//   reset : asynchronous active-high reset
//   i_det : raw asynchronous detect line
//   o_hit : one-cycle pulse, high 3 cycles after a rising edge is sampled
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_det,
  output logic o_hit
);

  // [0] first sync flop, [1] second sync flop, [2] previous synchronized level
  logic [2:0] r_sync;
  logic       r_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], i_det};
      r_hit  <= r_sync[1] & ~r_sync[2];
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/tdoa_coder.sv
// -----------------------------------------------------------------------------
// tdoa_coder
// Timestamps the first rising edge of four cross-arranged sensors within a
// capture window and publishes, per opposing pair, how many ticks one sensor
// lagged the other. After a publish or a window timeout, inputs are ignored
// for HOLDOFF cycles.
// Parameters:
//   TICK_DIV : clock cycles per timestamp tick (1..255)
//   WINDOW   : capture window in ticks from the first edge (1..255)
//   HOLDOFF  : cycles ignored after publish/timeout (1..65535)
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   io_tdoa      : slave side of tdoa_coder_if (detect lines in, codes out)
// -----------------------------------------------------------------------------
module tdoa_coder
  import tdoa_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned WINDOW   = 200,
  parameter int unsigned HOLDOFF  = 1000
) (
  input  logic         clock,
  input  logic         reset,
  tdoa_coder_if.slave  io_tdoa
);

  localparam logic [7:0]        PRESC_LAST = 8'(TICK_DIV - 1);
  localparam logic [TS_W-1:0]   TICK_LAST  = TS_W'(WINDOW - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLDOFF - 1);

  // Channel order: 0 = x1, 1 = x2, 2 = y1, 3 = y2
  logic [3:0] w_hit;

  edge_sync u_sync_x1 (.clock(clock), .reset(reset), .i_det(io_tdoa.det_x1), .o_hit(w_hit[0]));
  edge_sync u_sync_x2 (.clock(clock), .reset(reset), .i_det(io_tdoa.det_x2), .o_hit(w_hit[1]));
  edge_sync u_sync_y1 (.clock(clock), .reset(reset), .i_det(io_tdoa.det_y1), .o_hit(w_hit[2]));
  edge_sync u_sync_y2 (.clock(clock), .reset(reset), .i_det(io_tdoa.det_y2), .o_hit(w_hit[3]));

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [7:0]             r_presc;
  logic [TS_W-1:0]        r_tick;
  logic [HOLD_W-1:0]      r_hold;
  logic [3:0]             r_cap;
  logic [3:0][TS_W-1:0]   r_ts;
  logic [CODE_W-1:0]      r_code_x1;
  logic [CODE_W-1:0]      r_code_x2;
  logic [CODE_W-1:0]      r_code_y1;
  logic [CODE_W-1:0]      r_code_y2;
  logic                   r_code_valid;
  logic                   r_timeout;

  logic                   w_counting;
  logic [3:0]             w_new;
  logic                   w_all;
  logic                   w_wrap;
  logic                   w_expire;
  logic                   w_timeout_nxt;
  logic signed [TS_W:0]   w_d_x12;
  logic signed [TS_W:0]   w_d_x21;
  logic signed [TS_W:0]   w_d_y12;
  logic signed [TS_W:0]   w_d_y21;

  // The first-hit cycle in IDLE is tick 0 and the prescaler already advances
  // on it, so IDLE-with-hit and CAPTURE share the same capture/count logic.
  assign w_counting    = ((r_state == IDLE) && (|w_hit)) || (r_state == CAPTURE);
  assign w_new         = w_counting ? (w_hit & ~r_cap) : 4'b0000;
  assign w_all         = &(r_cap | w_new);
  assign w_wrap        = (r_presc == PRESC_LAST);
  // Expiry is flagged on the wrap that would make the tick count reach WINDOW,
  // so the strobe appears exactly WINDOW*TICK_DIV cycles after the first hit.
  assign w_expire      = w_wrap && (r_tick == TICK_LAST);
  assign w_timeout_nxt = w_counting && !w_all && w_expire;

  assign w_d_x12 = $signed({1'b0, r_ts[0]}) - $signed({1'b0, r_ts[1]});
  assign w_d_x21 = $signed({1'b0, r_ts[1]}) - $signed({1'b0, r_ts[0]});
  assign w_d_y12 = $signed({1'b0, r_ts[2]}) - $signed({1'b0, r_ts[3]});
  assign w_d_y21 = $signed({1'b0, r_ts[3]}) - $signed({1'b0, r_ts[2]});

  // NOTE: the default assignment first means every path assigns the next
  // state, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, CAPTURE: begin
        if (w_counting) begin
          if (w_all) begin
            w_state_nxt = COMPUTE;
          end else if (w_expire) begin
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = CAPTURE;
          end
        end
      end
      COMPUTE: w_state_nxt = HOLD;
      HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_tick       <= '0;
      r_hold       <= '0;
      r_cap        <= '0;
      // NOTE: the four timestamps are plain flops, not a RAM, so they take
      // the async reset like any other state.
      r_ts         <= '0;
      r_code_x1    <= '0;
      r_code_x2    <= '0;
      r_code_y1    <= '0;
      r_code_y2    <= '0;
      r_code_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_timeout    <= w_timeout_nxt;
      r_code_valid <= (r_state == COMPUTE);

      if (w_counting) begin
        if (w_wrap) begin
          r_presc <= '0;
          r_tick  <= r_tick + 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
        r_cap <= r_cap | w_new;
      end else begin
        r_presc <= '0;
        r_tick  <= '0;
        r_cap   <= '0;
      end

      for (int i = 0; i < 4; i++) begin
        if (w_new[i]) begin
          r_ts[i] <= r_tick;
        end
      end

      if (r_state == HOLD) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end

      if (r_state == COMPUTE) begin
        r_code_x1 <= sat127(w_d_x12);
        r_code_x2 <= sat127(w_d_x21);
        r_code_y1 <= sat127(w_d_y12);
        r_code_y2 <= sat127(w_d_y21);
      end
    end
  end

  assign io_tdoa.code_x1    = r_code_x1;
  assign io_tdoa.code_x2    = r_code_x2;
  assign io_tdoa.code_y1    = r_code_y1;
  assign io_tdoa.code_y2    = r_code_y2;
  assign io_tdoa.code_valid = r_code_valid;
  assign io_tdoa.timeout    = r_timeout;
  assign io_tdoa.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_tdoa_coder.sv
// -----------------------------------------------------------------------------
// tb_tdoa_coder
// Two coder instances share the same detect lines: A (TICK_DIV=1, WINDOW=255)
// and B (TICK_DIV=4, WINDOW=50). For each scenario the expected strobe kind,
// codes and strobe cycle are predicted per instance from the arrival offsets
// and pushed into a queue; a negedge monitor pops and compares on every
// code_valid/timeout strobe.
// -----------------------------------------------------------------------------
module tb_tdoa_coder;

  localparam int TD_A = 1;
  localparam int WIN_A = 255;
  localparam int HO_A = 40;
  localparam int TD_B = 4;
  localparam int WIN_B = 50;
  localparam int HO_B = 60;

  typedef struct packed {
    logic        is_valid;
    logic [27:0] codes;
    int          at;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  det;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a;
  exp_t        e_b;
  logic [27:0] prev_a;
  logic [27:0] prev_b;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  tdoa_coder_if bus_a ();
  tdoa_coder_if bus_b ();

  assign bus_a.det_x1 = det[0];
  assign bus_a.det_x2 = det[1];
  assign bus_a.det_y1 = det[2];
  assign bus_a.det_y2 = det[3];
  assign bus_b.det_x1 = det[0];
  assign bus_b.det_x2 = det[1];
  assign bus_b.det_y1 = det[2];
  assign bus_b.det_y2 = det[3];

  tdoa_coder #(.TICK_DIV(TD_A), .WINDOW(WIN_A), .HOLDOFF(HO_A)) dut_a (
    .clock(clock), .reset(reset), .io_tdoa(bus_a)
  );
  tdoa_coder #(.TICK_DIV(TD_B), .WINDOW(WIN_B), .HOLDOFF(HO_B)) dut_b (
    .clock(clock), .reset(reset), .io_tdoa(bus_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sat(input int d);
    if (d <= 0) return 0;
    if (d > 127) return 127;
    return d;
  endfunction

  // Expected outcome from raw arrival offsets (cycles from scenario start,
  // -1 = channel never fires). Channel order x1, x2, y1, y2.
  function automatic exp_t predict(input int rel[4], input int td, input int win,
                                   input int start, input logic [27:0] prev);
    exp_t e;
    int   first;
    int   last;
    int   t[4];
    bit   complete;
    first = 1 << 30;
    last = -1;
    complete = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (rel[c] < 0) complete = 1'b0;
      else begin
        if (rel[c] < first) first = rel[c];
        if (rel[c] > last) last = rel[c];
      end
    end
    if (complete && (last - first) <= win * td - 1) begin
      for (int c = 0; c < 4; c++) t[c] = (rel[c] - first) / td;
      e.is_valid = 1'b1;
      e.codes = {7'(sat(t[0] - t[1])), 7'(sat(t[1] - t[0])),
                 7'(sat(t[2] - t[3])), 7'(sat(t[3] - t[2]))};
      e.at = start + first + 3 + (last - first) + 2;
    end else begin
      e.is_valid = 1'b0;
      e.codes = prev;
      e.at = start + first + 3 + win * td;
    end
    return e;
  endfunction

  task automatic compare_item(input string tag, input exp_t e, input logic v,
                              input logic t, input logic [27:0] codes);
    check({tag, "_kind"}, {v, t}, e.is_valid ? 2'b10 : 2'b01);
    check({tag, "_codes"}, codes, e.codes);
    check({tag, "_cycle"}, cyc, e.at);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus_a.code_valid || bus_a.timeout) begin
        check("a_strobe_expected", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          e_a = q_a.pop_front();
          compare_item("a", e_a, bus_a.code_valid, bus_a.timeout,
                       {bus_a.code_x1, bus_a.code_x2, bus_a.code_y1, bus_a.code_y2});
        end
      end
      if (bus_b.code_valid || bus_b.timeout) begin
        check("b_strobe_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          e_b = q_b.pop_front();
          compare_item("b", e_b, bus_b.code_valid, bus_b.timeout,
                       {bus_b.code_x1, bus_b.code_x2, bus_b.code_y1, bus_b.code_y2});
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_a_outputs"},
          {bus_a.code_x1, bus_a.code_x2, bus_a.code_y1, bus_a.code_y2,
           bus_a.code_valid, bus_a.timeout, bus_a.busy}, 0);
    check({tag, "_b_outputs"},
          {bus_b.code_x1, bus_b.code_x2, bus_b.code_y1, bus_b.code_y2,
           bus_b.code_valid, bus_b.timeout, bus_b.busy}, 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus_a.busy || bus_b.busy) && n < 2000) begin
      step();
      n++;
    end
    check("busy_release", {bus_a.busy, bus_b.busy}, 0);
    repeat (5) step();
  endtask

  // Drives one scenario; with poke_hold, raises x1 again while both
  // instances sit in HOLD (only meaningful for all-zero offsets).
  task automatic run_scenario(input int rel[4], input bit poke_hold);
    exp_t ea;
    exp_t eb;
    int   start;
    int   maxrel;
    start = cyc;
    ea = predict(rel, TD_A, WIN_A, start, prev_a);
    eb = predict(rel, TD_B, WIN_B, start, prev_b);
    q_a.push_back(ea);
    q_b.push_back(eb);
    if (ea.is_valid) prev_a = ea.codes;
    if (eb.is_valid) prev_b = eb.codes;
    maxrel = 0;
    for (int c = 0; c < 4; c++) if (rel[c] > maxrel) maxrel = rel[c];
    for (int o = 0; o <= maxrel; o++) begin
      for (int c = 0; c < 4; c++) if (rel[c] == o) det[c] = 1'b1;
      step();
    end
    repeat (3) step();
    det = '0;
    if (poke_hold) begin
      repeat (4) step();
      det[0] = 1'b1;
      while (cyc < start + 12) step();
      check("a_hold_busy", bus_a.busy, 1);
      check("b_hold_busy", bus_b.busy, 1);
      repeat (3) step();
      det = '0;
    end
    wait_idle();
  endtask

  initial begin
    int r[4];
    int mode;
    det = '0;
    reset = 1'b1;
    prev_a = '0;
    prev_b = '0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) step();

    r = '{10, 0, 20, 25};
    run_scenario(r, 1'b0);
    r = '{0, 5, 9, -1};
    run_scenario(r, 1'b0);
    r = '{200, 0, 0, 0};
    run_scenario(r, 1'b0);
    r = '{0, 0, 0, 0};
    run_scenario(r, 1'b1);

    // Reset in the middle of a capture window.
    det[0] = 1'b1;
    repeat (2) step();
    det[1] = 1'b1;
    repeat (8) step();
    check("pre_reset_busy", {bus_a.busy, bus_b.busy}, 2'b11);
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    prev_a = '0;
    prev_b = '0;
    repeat (2) step();
    det = '0;
    repeat (2) step();
    reset = 1'b0;
    repeat (30) step();
    check_all_zero("post_reset");

    for (int s = 0; s < 24; s++) begin
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 4; c++) begin
        if (mode == 0) r[c] = 3;
        else if (mode == 1) r[c] = $urandom_range(0, 15);
        else r[c] = $urandom_range(0, 250);
        if ($urandom_range(0, 9) == 0) r[c] = -1;
      end
      if (r[0] < 0 && r[1] < 0 && r[2] < 0 && r[3] < 0) r[0] = 0;
      run_scenario(r, 1'b0);
    end

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
